// File: rtl/sha256_w_window_feeder.sv
// sha256_w_window_feeder: source side of a registered SHA-256 W-expander.
// Stores one 16-word message block in a circular buffer (address = t mod 16),
// issues one tap window {W[t-16],W[t-15],W[t-7],W[t-2],lane5} per cycle,
// captures the expander result one cycle later and streams W[0..LAST_T] in
// index order to the round core.
// Optional feature macro: SHA256_W_FEEDER_LANE5_EN (lane5 = W[t-1] with a
// bypass from fb_word); when undefined lane5 is tied to zero.
module sha256_w_window_feeder #(
   parameter int LAST_T = 63
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_word,
   input  logic         hold,
   output logic [159:0] win_out,
   output logic         exp_we,
   input  logic [31:0]  fb_word,
   output logic         wt_valid,
   output logic [31:0]  wt_out,
   output logic [5:0]   wt_index,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {IDLE, LOAD, EXPAND, DRAIN, DONE} state_t;

   state_t        state, state_nx;
   logic [6:0]    t;
   logic [5:0]    t_issued;
   logic          fb_pend;
   logic [31:0]   wbuf [16];
   logic [159:0]  win_q, win_now;
   logic [31:0]   lane5;
   logic          accept, issue;
   logic [3:0]    a15, a7, a2;

   assign accept   = (state == LOAD) && in_valid;
   assign issue    = (state == EXPAND) && !hold;
   assign in_ready = (state == LOAD);
   assign exp_we   = issue;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   // Tap addresses: t-16 aliases t in a 16-deep ring; the rest are mod-16 offsets.
   assign a15 = t[3:0] + 4'd1;
   assign a7  = t[3:0] + 4'd9;
   assign a2  = t[3:0] + 4'd14;

`ifdef SHA256_W_FEEDER_LANE5_EN
   logic [3:0] a1;
   assign a1 = t[3:0] + 4'd15;
   // W[t-1] is still in flight from the expander when the previous cycle issued.
   assign lane5 = fb_pend ? fb_word : wbuf[a1];
`else
   assign lane5 = 32'h0;
`endif

   // W[t-2] was captured at the end of the cycle that issued t-1, so buffer
   // reads for lanes 1-4 are always current without a bypass.
   assign win_now = {wbuf[t[3:0]], wbuf[a15], wbuf[a7], wbuf[a2], lane5};
   assign win_out = issue ? win_now : win_q;

   // Next-state selection for the load / expand / drain sequence.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = LOAD;
         LOAD:    if (accept && t == 7'd15) state_nx = EXPAND;
         EXPAND:  if (issue && t == 7'(LAST_T)) state_nx = DRAIN;
         DRAIN:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Control state, schedule index and the registered W output stream.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         t        <= '0;
         t_issued <= '0;
         fb_pend  <= 1'b0;
         win_q    <= '0;
         wt_valid <= 1'b0;
         wt_out   <= '0;
         wt_index <= '0;
      end else begin
         state    <= state_nx;
         wt_valid <= 1'b0;
         // A pending result is taken exactly once, even if hold freezes fb_word.
         fb_pend  <= issue;
         if (accept) begin
            wt_valid <= 1'b1;
            wt_out   <= in_word;
            wt_index <= t[5:0];
            t        <= t + 7'd1;
         end
         if (fb_pend) begin
            wt_valid <= 1'b1;
            wt_out   <= fb_word;
            wt_index <= t_issued;
         end
         if (issue) begin
            win_q    <= win_now;
            t_issued <= t[5:0];
            t        <= t + 7'd1;
         end
         if (state == DONE) t <= '0;
      end
   end

   // Schedule ring: message words while loading, expander results afterwards.
   always_ff @(posedge CLK) begin
      if (accept)
         wbuf[t[3:0]] <= in_word;
      else if (fb_pend)
         wbuf[t_issued[3:0]] <= fb_word;
   end

endmodule

// File: tb/tb_sha256_w_window_feeder.sv
// Bench for sha256_w_window_feeder: two instances (LAST_T=63 and LAST_T=60)
// share stimulus; each has its own behavioural expander. The expected W stream
// and windows come from a plain SHA-256 message-schedule model.
module tb_sha256_w_window_feeder;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic in_valid = 1'b0;
   logic hold = 1'b0;
   logic [31:0] in_word = '0;
   logic [31:0] fb_a = '0, fb_b = '0;

   logic in_ready_a, exp_we_a, wt_valid_a, busy_a, done_a;
   logic in_ready_b, exp_we_b, wt_valid_b, busy_b, done_b;
   logic [159:0] win_a, win_b;
   logic [31:0] wt_out_a, wt_out_b;
   logic [5:0] wt_idx_a, wt_idx_b;

   logic [1:0] in_ready, exp_we, wt_valid, busy, done;
   logic [1:0][159:0] win;
   logic [1:0][31:0] wt_out;
   logic [1:0][5:0] wt_idx;
   assign in_ready = {in_ready_b, in_ready_a};
   assign exp_we   = {exp_we_b, exp_we_a};
   assign wt_valid = {wt_valid_b, wt_valid_a};
   assign busy     = {busy_b, busy_a};
   assign done     = {done_b, done_a};
   assign win      = {win_b, win_a};
   assign wt_out   = {wt_out_b, wt_out_a};
   assign wt_idx   = {wt_idx_b, wt_idx_a};

   int last_t [2] = '{63, 60};
   logic [31:0] msg [16];
   logic [31:0] W [64];
   logic [31:0] got_val [2][80];
   int got_n [2], issue_n [2], done_n [2], done_cyc [2];
   int cyc = 0;
   int checks = 0, failures = 0;
   int m_t;
   logic [31:0] m_l5;
   logic [159:0] m_win;

   sha256_w_window_feeder #(.LAST_T(63)) dut_a (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_a), .in_word(in_word),
      .hold(hold), .win_out(win_a), .exp_we(exp_we_a), .fb_word(fb_a), .wt_valid(wt_valid_a),
      .wt_out(wt_out_a), .wt_index(wt_idx_a), .busy(busy_a), .done(done_a));

   sha256_w_window_feeder #(.LAST_T(60)) dut_b (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_b), .in_word(in_word),
      .hold(hold), .win_out(win_b), .exp_we(exp_we_b), .fb_word(fb_b), .wt_valid(wt_valid_b),
      .wt_out(wt_out_b), .wt_index(wt_idx_b), .busy(busy_b), .done(done_b));

   always #5 CLK = ~CLK;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Behavioural expander: registered W[t] from the window, held when idle.
   always @(posedge CLK) begin
      if (exp_we_a) fb_a <= sig1(win_a[63:32]) + win_a[95:64] + sig0(win_a[127:96]) + win_a[159:128];
   end
   always @(posedge CLK) begin
      if (exp_we_b) fb_b <= sig1(win_b[63:32]) + win_b[95:64] + sig0(win_b[127:96]) + win_b[159:128];
   end

   task automatic build_sched();
      for (int i = 0; i < 16; i++) W[i] = msg[i];
      for (int i = 16; i < 64; i++) W[i] = sig1(W[i-2]) + W[i-7] + sig0(W[i-15]) + W[i-16];
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) msg[i] = 32'h0;
      msg[0] = 32'h61626380;
      msg[15] = 32'h00000018;
      build_sched();
   endtask

   task automatic set_random();
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      build_sched();
   endtask

   task automatic clear_counts();
      for (int k = 0; k < 2; k++) begin
         got_n[k] = 0; issue_n[k] = 0; done_n[k] = 0; done_cyc[k] = -100;
      end
   endtask

   // Monitor: stream order/values, window contents, in_ready, done and busy.
   always @(negedge CLK) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (cyc == done_cyc[k] + 1) begin
            checks++;
            if (busy[k] !== 1'b0) begin
               failures++; $display("FAIL busy_after_done dut%0d: got %b want 0", k, busy[k]);
            end
         end
         if (wt_valid[k] === 1'b1) begin
            checks++;
            if (got_n[k] > last_t[k]) begin
               failures++; $display("FAIL extra_word dut%0d: got idx %0d after last %0d", k, wt_idx[k], last_t[k]);
            end else if (wt_idx[k] !== 6'(got_n[k]) || wt_out[k] !== W[got_n[k]]) begin
               failures++;
               $display("FAIL stream dut%0d: got idx %0d val %h want idx %0d val %h",
                        k, wt_idx[k], wt_out[k], got_n[k], W[got_n[k]]);
            end
            if (got_n[k] < 80) begin got_val[k][got_n[k]] = wt_out[k]; got_n[k]++; end
         end
         if (exp_we[k] === 1'b1) begin
            m_t = 16 + issue_n[k];
            checks++;
            if (m_t > last_t[k]) begin
               failures++; $display("FAIL extra_issue dut%0d: got t=%0d want <= %0d", k, m_t, last_t[k]);
            end else begin
`ifdef SHA256_W_FEEDER_LANE5_EN
               m_l5 = W[m_t-1];
`else
               m_l5 = 32'h0;
`endif
               m_win = {W[m_t-16], W[m_t-15], W[m_t-7], W[m_t-2], m_l5};
               if (win[k] !== m_win) begin
                  failures++; $display("FAIL window dut%0d t=%0d: got %h want %h", k, m_t, win[k], m_win);
               end
            end
            issue_n[k]++;
         end
         if (got_n[k] >= 16 && done_n[k] == 0) begin
            checks++;
            if (in_ready[k] !== 1'b0) begin
               failures++; $display("FAIL in_ready_expand dut%0d: got %b want 0", k, in_ready[k]);
            end
         end
         if (done[k] === 1'b1) begin
            checks++;
            done_n[k]++;
            done_cyc[k] = cyc;
            if (got_n[k] != last_t[k] + 1) begin
               failures++; $display("FAIL done_early dut%0d: words %0d want %0d", k, got_n[k], last_t[k] + 1);
            end
         end
      end
   end

   task automatic do_reset();
      in_valid = 1'b0; hold = 1'b0; RST = 1'b1;
      clear_counts();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic load_block(input bit gap, input bit keep_valid);
      int i = 0;
      int g = 0;
      bit acc;
      while (i < 16 && g < 100) begin
         if (gap && (g % 2 == 1)) in_valid = 1'b0;
         else begin in_valid = 1'b1; in_word = msg[i]; end
         acc = in_valid && in_ready_a;
         @(posedge CLK); #1; g++;
         if (acc) i++;
      end
      if (keep_valid) begin in_valid = 1'b1; in_word = 32'hDEADBEEF; end
      else in_valid = 1'b0;
      checks++;
      if (i != 16) begin failures++; $display("FAIL load_timeout: got %0d words want 16", i); end
   endtask

   task automatic wait_done(input bit rnd_hold);
      int g = 0;
      while (!(done_n[0] > 0 && done_n[1] > 0) && g < 300) begin
         if (done_a || done_b) in_valid = 1'b0;
         if (rnd_hold) hold = ($urandom_range(0, 3) == 0);
         @(posedge CLK); #1; g++;
      end
      in_valid = 1'b0; hold = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (g >= 300) begin failures++; $display("FAIL done_timeout: got %0d/%0d want 1/1", done_n[0], done_n[1]); end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #3;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({in_ready[k], exp_we[k], wt_valid[k], busy[k], done[k]} !== 5'b0) begin
            failures++; $display("FAIL reset_flags dut%0d: got %b want 00000", k,
                                 {in_ready[k], exp_we[k], wt_valid[k], busy[k], done[k]});
         end
         checks++;
         if (win[k] !== 160'h0 || wt_out[k] !== 32'h0 || wt_idx[k] !== 6'h0) begin
            failures++; $display("FAIL reset_data dut%0d: got win %h out %h idx %0d want 0", k, win[k], wt_out[k], wt_idx[k]);
         end
      end
      do_reset();
      checks++;
      if (busy !== 2'b00 || in_ready !== 2'b00) begin
         failures++; $display("FAIL idle_after_reset: got busy %b in_ready %b want 00 00", busy, in_ready);
      end
   endtask

   task automatic test_abc();
      do_reset();
      set_abc();
      load_block(1'b0, 1'b0);
      wait_done(1'b0);
      checks++;
      if (got_n[0] != 64 || issue_n[0] != 48 || done_n[0] != 1) begin
         failures++; $display("FAIL abc_counts: got words %0d issues %0d done %0d want 64 48 1", got_n[0], issue_n[0], done_n[0]);
      end
      checks++;
      if (got_val[0][16] !== 32'h61626380) begin
         failures++; $display("FAIL abc_w16: got %h want 61626380", got_val[0][16]);
      end
      checks++;
      if (got_val[0][17] !== 32'h000F0000) begin
         failures++; $display("FAIL abc_w17: got %h want 000f0000", got_val[0][17]);
      end
   endtask

   task automatic test_hold();
      int g = 0;
      do_reset();
      set_abc();
      load_block(1'b0, 1'b0);
      while (issue_n[0] < 5 && g < 100) begin @(posedge CLK); #1; g++; end
      checks++;
      if (issue_n[0] != 5) begin failures++; $display("FAIL hold_sync: got issues %0d want 5", issue_n[0]); end
      for (int h = 0; h < 3; h++) begin
         hold = 1'b1;
         #2;
         checks++;
         if (exp_we !== 2'b00) begin failures++; $display("FAIL hold_we cycle %0d: got %b want 00", h, exp_we); end
         @(posedge CLK); #1;
      end
      hold = 1'b0;
      wait_done(1'b0);
      checks++;
      if (got_n[0] != 64 || issue_n[0] != 48 || got_val[0][20] !== W[20]) begin
         failures++; $display("FAIL hold_stream: got words %0d issues %0d w20 %h want 64 48 %h",
                              got_n[0], issue_n[0], got_val[0][20], W[20]);
      end
   endtask

   task automatic test_last_t();
      do_reset();
      set_random();
      load_block(1'b0, 1'b0);
      wait_done(1'b0);
      checks++;
      if (got_n[1] != 61 || issue_n[1] != 45 || done_n[1] != 1) begin
         failures++; $display("FAIL last60_counts: got words %0d issues %0d done %0d want 61 45 1", got_n[1], issue_n[1], done_n[1]);
      end
      checks++;
      if (got_val[1][60] !== W[60]) begin
         failures++; $display("FAIL last60_w60: got %h want %h", got_val[1][60], W[60]);
      end
   endtask

   task automatic test_gapped_ignore();
      do_reset();
      set_random();
      load_block(1'b1, 1'b1);
      wait_done(1'b0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_n[k] != last_t[k] + 1 || done_n[k] != 1) begin
            failures++; $display("FAIL gapped_counts dut%0d: got words %0d done %0d want %0d 1", k, got_n[k], done_n[k], last_t[k] + 1);
         end
      end
   endtask

   task automatic test_reset_mid();
      int g = 0;
      do_reset();
      set_random();
      load_block(1'b0, 1'b0);
      while (got_n[0] < 30 && g < 100) begin @(posedge CLK); #1; g++; end
      #2 RST = 1'b1;
      #1;
      checks++;
      if ({exp_we, wt_valid, busy, done, in_ready} !== 10'b0 || win !== '0 || wt_out !== '0 || wt_idx !== '0) begin
         failures++; $display("FAIL async_reset: got flags %b win %h out %h want all 0",
                              {exp_we, wt_valid, busy, done, in_ready}, win, wt_out);
      end
      clear_counts();
      @(posedge CLK); #1 RST = 1'b0;
      set_random();
      load_block(1'b0, 1'b0);
      wait_done(1'b0);
      checks++;
      if (got_n[0] != 64 || got_val[0][16] !== W[16] || got_val[0][17] !== W[17]) begin
         failures++; $display("FAIL after_reset: got words %0d w16 %h w17 %h want 64 %h %h",
                              got_n[0], got_val[0][16], got_val[0][17], W[16], W[17]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int b = 0; b < 3; b++) begin
         clear_counts();
         set_random();
         load_block(1'($urandom_range(0, 1)), 1'b0);
         wait_done(1'b1);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_n[k] != last_t[k] + 1 || issue_n[k] != last_t[k] - 15 || done_n[k] != 1) begin
               failures++; $display("FAIL b2b blk%0d dut%0d: got words %0d issues %0d done %0d want %0d %0d 1",
                                    b, k, got_n[k], issue_n[k], done_n[k], last_t[k] + 1, last_t[k] - 15);
            end
         end
      end
   endtask

   initial begin
      clear_counts();
      test_reset();
      test_abc();
      test_hold();
      test_last_t();
      test_gapped_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
